// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//
// Age-ordered issue queue and scheduler for one integer execute unit
// (adder, logCmp or shift class). It sits between dispatch and the unit.
// It buffers dispatched micro-ops and tracks operand readiness against the
// physical-register ready vector plus the writeback wakeup bus. Every cycle
// it moves the oldest ready entry into a registered issue slot that talks to
// the unit over a valid/ready handshake.
//
// Storage is a compacting shift queue. Index 0 is the oldest entry, and valid
// entries are contiguous from index 0. When an entry is selected, every entry
// above it moves down by one on the same edge.
//
// Optional feature macro: ISSUE_BYPASS_EN
//   defined   - if the queue holds no ready entry, a dispatch whose operands
//               are ready that cycle loads the issue slot directly when the
//               slot is free or draining. Latency is then t+1 and the queue
//               is not written.
//   undefined - every op passes through the queue. Minimum latency is t+2.
//
// Ports:
//   CLK, RSTn           clock, asynchronous active-low reset
//   flush               clears queue and issue slot on the next edge
//   dispat_vaild/ready  dispatch handshake (ready = occupancy < DP)
//   dispat_info         opaque payload (DW bits)
//   dispat_rs1/rs2      source physical indices, with read enables _en
//   reg_ready           per-physical-register written-back flags
//   wb_vaild/wb_rd      same-cycle writeback wakeup
//   exe_vaild/ready     issue-slot handshake toward the execute unit
//   exe_info/rs1/rs2    issued payload and sources (stable under stall)
//   occupancy           valid queue entries, issue slot excluded
// ---------------------------------------------------------------------------
`default_nettype none

module alu_issue_queue #(
  parameter int DP    = 4,
  parameter int RNBIT = 2,
  parameter int DW    = 200
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    flush,
  input  logic                    dispat_vaild,
  output logic                    dispat_ready,
  input  logic [DW-1:0]           dispat_info,
  input  logic [5+RNBIT-1:0]      dispat_rs1,
  input  logic [5+RNBIT-1:0]      dispat_rs2,
  input  logic                    dispat_rs1_en,
  input  logic                    dispat_rs2_en,
  input  logic [2**(5+RNBIT)-1:0] reg_ready,
  input  logic                    wb_vaild,
  input  logic [5+RNBIT-1:0]      wb_rd,
  output logic                    exe_vaild,
  input  logic                    exe_ready,
  output logic [DW-1:0]           exe_info,
  output logic [5+RNBIT-1:0]      exe_rs1,
  output logic [5+RNBIT-1:0]      exe_rs2,
  output logic [$clog2(DP):0]     occupancy
);

  localparam int PW = 5 + RNBIT;
  localparam int NR = 2 ** PW;
  localparam int CW = $clog2(DP) + 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_DP   = CW'(DP);

  typedef struct packed {
    logic [DW-1:0] info;
    logic [PW-1:0] rs1;
    logic [PW-1:0] rs2;
    logic          rs1_en;
    logic          rs2_en;
  } entry_t;

  localparam int     EW       = $bits(entry_t);
  localparam entry_t ENT_ZERO = entry_t'({EW{1'b0}});

  // A source is ready if the op does not read it, or it is the hard-wired
  // zero register, or it is already written back, or it is being written
  // back this very cycle. The last case is the same-cycle wakeup bypass.
  function automatic logic src_ready(
    input logic          en,
    input logic [PW-1:0] idx,
    input logic [NR-1:0] rdy_vec,
    input logic          wb_v,
    input logic [PW-1:0] wb_idx
  );
    src_ready = ~en | (idx == {PW{1'b0}}) | rdy_vec[idx] | (wb_v & (wb_idx == idx));
  endfunction

  // Queue state
  entry_t          q_r [DP];
  logic [DP-1:0]   q_valid_r;
  logic [CW-1:0]   occ_r;
  logic            dispat_ready_r;

  // Issue slot state
  logic            slot_v_r;
  logic [DW-1:0]   slot_info_r;
  logic [PW-1:0]   slot_rs1_r;
  logic [PW-1:0]   slot_rs2_r;

  // Combinational control
  entry_t          dis_ent_s;
  logic [DP-1:0]   ent_rdy_s;
  logic            sel_found_s;
  logic [CW-1:0]   sel_idx_s;
  logic [DW-1:0]   sel_info_s;
  logic [PW-1:0]   sel_rs1_s;
  logic [PW-1:0]   sel_rs2_s;
  logic            slot_free_s;
  logic            deq_s;
  logic            acc_s;
  logic            byp_s;
  logic            push_s;
  logic [CW-1:0]   wr_idx_s;
  logic [CW-1:0]   occ_nxt_s;
  entry_t          q_ext_s [DP+1];
  logic [DP:0]     v_ext_s;
  entry_t          q_nxt_s [DP];
  logic [DP-1:0]   v_nxt_s;

  // Pack the dispatch ports into one entry record.
  always_comb begin
    dis_ent_s.info   = dispat_info;
    dis_ent_s.rs1    = dispat_rs1;
    dis_ent_s.rs2    = dispat_rs2;
    dis_ent_s.rs1_en = dispat_rs1_en;
    dis_ent_s.rs2_en = dispat_rs2_en;
  end

  // Compute per-entry readiness: valid and both sources ready.
  always_comb begin
    ent_rdy_s = {DP{1'b0}};
    for (int i = 0; i < DP; i++) begin
      ent_rdy_s[i] = q_valid_r[i]
                   & src_ready(q_r[i].rs1_en, q_r[i].rs1, reg_ready, wb_vaild, wb_rd)
                   & src_ready(q_r[i].rs2_en, q_r[i].rs2, reg_ready, wb_vaild, wb_rd);
    end
  end

  // Pick the oldest ready entry. The lowest index wins, so age is the only
  // priority.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = CNT_ZERO;
    sel_info_s  = q_r[0].info;
    sel_rs1_s   = q_r[0].rs1;
    sel_rs2_s   = q_r[0].rs2;
    for (int i = 0; i < DP; i++) begin
      if (ent_rdy_s[i] && !sel_found_s) begin
        sel_found_s = 1'b1;
        sel_idx_s   = CW'(i);
        sel_info_s  = q_r[i].info;
        sel_rs1_s   = q_r[i].rs1;
        sel_rs2_s   = q_r[i].rs2;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Handshake and movement decisions for this cycle.
  // Dispatch is gated on the registered full flag, so a full queue refuses
  // an op even when an entry leaves on the same edge.
  always_comb begin
    slot_free_s = ~slot_v_r | exe_ready;
    deq_s       = slot_free_s & sel_found_s & ~flush;
    acc_s       = dispat_vaild & dispat_ready_r & ~flush;
`ifdef ISSUE_BYPASS_EN
    byp_s       = acc_s & slot_free_s & ~sel_found_s
                & src_ready(dispat_rs1_en, dispat_rs1, reg_ready, wb_vaild, wb_rd)
                & src_ready(dispat_rs2_en, dispat_rs2, reg_ready, wb_vaild, wb_rd);
`else
    byp_s       = 1'b0;
`endif
    push_s      = acc_s & ~byp_s;
    // A removal compacts the queue first, so the new op lands one slot lower.
    wr_idx_s    = deq_s ? (occ_r - CNT_ONE) : occ_r;
  end

  // Next occupancy: +1 on push, -1 on select, unchanged when both happen.
  always_comb begin
    occ_nxt_s = occ_r;
    if (flush) begin
      occ_nxt_s = CNT_ZERO;
    end else begin
      case ({push_s, deq_s})
        2'b10:   occ_nxt_s = occ_r + CNT_ONE;
        2'b01:   occ_nxt_s = occ_r - CNT_ONE;
        default: occ_nxt_s = occ_r;
      endcase
    end
  end

  // Next queue contents: shift down above the selected index, then write the
  // accepted dispatch at the tail. An extra always-empty top element lets the
  // topmost entry shift in zeros without an out-of-range read.
  always_comb begin
    for (int i = 0; i < DP; i++) begin
      q_ext_s[i] = q_r[i];
    end
    q_ext_s[DP] = ENT_ZERO;
    v_ext_s     = {1'b0, q_valid_r};
    v_nxt_s     = {DP{1'b0}};
    for (int i = 0; i < DP; i++) begin
      q_nxt_s[i] = (push_s && (CW'(i) == wr_idx_s)) ? dis_ent_s :
                   ((deq_s && (CW'(i) >= sel_idx_s)) ? q_ext_s[i+1] : q_r[i]);
      v_nxt_s[i] = flush ? 1'b0 :
                   ((push_s && (CW'(i) == wr_idx_s)) ? 1'b1 :
                   ((deq_s && (CW'(i) >= sel_idx_s)) ? v_ext_s[i+1] : q_valid_r[i]));
    end
  end

  // Queue storage registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      q_valid_r <= {DP{1'b0}};
      for (int i = 0; i < DP; i++) begin
        q_r[i] <= ENT_ZERO;
      end
    end else begin
      q_valid_r <= v_nxt_s;
      for (int i = 0; i < DP; i++) begin
        q_r[i] <= q_nxt_s[i];
      end
    end
  end

  // Occupancy counter and registered dispatch-ready flag.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      occ_r          <= CNT_ZERO;
      dispat_ready_r <= 1'b1;
    end else begin
      occ_r          <= occ_nxt_s;
      dispat_ready_r <= (occ_nxt_s < CNT_DP);
    end
  end

  // Issue slot. It loads when empty or when the unit takes the current op.
  // A flush also discards the op being handed over that cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      slot_v_r    <= 1'b0;
      slot_info_r <= {DW{1'b0}};
      slot_rs1_r  <= {PW{1'b0}};
      slot_rs2_r  <= {PW{1'b0}};
    end else if (flush) begin
      slot_v_r    <= 1'b0;
      slot_info_r <= {DW{1'b0}};
      slot_rs1_r  <= {PW{1'b0}};
      slot_rs2_r  <= {PW{1'b0}};
    end else if (slot_free_s) begin
      if (deq_s) begin
        slot_v_r    <= 1'b1;
        slot_info_r <= sel_info_s;
        slot_rs1_r  <= sel_rs1_s;
        slot_rs2_r  <= sel_rs2_s;
      end else if (byp_s) begin
        slot_v_r    <= 1'b1;
        slot_info_r <= dispat_info;
        slot_rs1_r  <= dispat_rs1;
        slot_rs2_r  <= dispat_rs2;
      end else begin
        slot_v_r    <= 1'b0;
      end
    end else begin
      slot_v_r <= slot_v_r;
    end
  end

  assign dispat_ready = dispat_ready_r;
  assign exe_vaild    = slot_v_r;
  assign exe_info     = slot_info_r;
  assign exe_rs1      = slot_rs1_r;
  assign exe_rs2      = slot_rs2_r;
  assign occupancy    = occ_r;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
// ---------------------------------------------------------------------------
// Self-checking bench for alu_issue_queue. Directed scenarios compare
// outputs against constants. The randomized scenario compares them against
// a queue-based reference model of the issue rules.
// ---------------------------------------------------------------------------
module tb_alu_issue_queue;

  localparam int DP    = 4;
  localparam int RNBIT = 2;
  localparam int DW    = 200;
  localparam int PW    = 5 + RNBIT;
  localparam int NR    = 2 ** PW;

  logic            CLK = 1'b0;
  logic            RSTn;
  logic            flush;
  logic            dispat_vaild;
  logic            dispat_ready;
  logic [DW-1:0]   dispat_info;
  logic [PW-1:0]   dispat_rs1;
  logic [PW-1:0]   dispat_rs2;
  logic            dispat_rs1_en;
  logic            dispat_rs2_en;
  logic [NR-1:0]   reg_ready;
  logic            wb_vaild;
  logic [PW-1:0]   wb_rd;
  logic            exe_vaild;
  logic            exe_ready;
  logic [DW-1:0]   exe_info;
  logic [PW-1:0]   exe_rs1;
  logic [PW-1:0]   exe_rs2;
  logic [$clog2(DP):0] occupancy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_issue_queue #(.DP(DP), .RNBIT(RNBIT), .DW(DW)) dut (
    .CLK(CLK), .RSTn(RSTn), .flush(flush),
    .dispat_vaild(dispat_vaild), .dispat_ready(dispat_ready),
    .dispat_info(dispat_info), .dispat_rs1(dispat_rs1), .dispat_rs2(dispat_rs2),
    .dispat_rs1_en(dispat_rs1_en), .dispat_rs2_en(dispat_rs2_en),
    .reg_ready(reg_ready), .wb_vaild(wb_vaild), .wb_rd(wb_rd),
    .exe_vaild(exe_vaild), .exe_ready(exe_ready), .exe_info(exe_info),
    .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DW-1:0] info;
    logic [PW-1:0] rs1;
    logic [PW-1:0] rs2;
    logic          en1;
    logic          en2;
  } uop_t;

  uop_t m_q[$];
  uop_t m_slot;
  bit   m_slot_v;

  function automatic bit m_rdy(input logic en, input logic [PW-1:0] r);
    return (!en) || (r == 0) || reg_ready[r] || (wb_vaild && (wb_rd == r));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_slot   = '0;
    m_slot_v = 1'b0;
  endtask

  // Advance the model by one edge, using the inputs currently driven.
  task automatic model_step();
    int   sel = -1;
    bit   acc;
    uop_t d;
    d.info = dispat_info; d.rs1 = dispat_rs1; d.rs2 = dispat_rs2;
    d.en1  = dispat_rs1_en; d.en2 = dispat_rs2_en;
    acc = dispat_vaild && (m_q.size() < DP) && !flush;
    if (flush) begin
      model_reset();
      return;
    end
    for (int k = 0; k < m_q.size(); k++)
      if (sel < 0 && m_rdy(m_q[k].en1, m_q[k].rs1) && m_rdy(m_q[k].en2, m_q[k].rs2)) sel = k;
    if (!m_slot_v || exe_ready) begin
      if (sel >= 0) begin
        m_slot = m_q[sel]; m_slot_v = 1'b1; m_q.delete(sel);
      end
`ifdef ISSUE_BYPASS_EN
      else if (acc && m_rdy(d.en1, d.rs1) && m_rdy(d.en2, d.rs2)) begin
        m_slot = d; m_slot_v = 1'b1; acc = 1'b0;
      end
`endif
      else m_slot_v = 1'b0;
    end
    if (acc) m_q.push_back(d);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    dispat_vaild = 1'b0; wb_vaild = 1'b0; flush = 1'b0;
  endtask

  task automatic drive(input logic [DW-1:0] info, input logic [PW-1:0] r1,
                       input logic [PW-1:0] r2, input logic e1, input logic e2);
    dispat_vaild = 1'b1; dispat_info = info; dispat_rs1 = r1; dispat_rs2 = r2;
    dispat_rs1_en = e1; dispat_rs2_en = e2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RSTn = 1'b0; idle(); exe_ready = 1'b0; reg_ready = {NR{1'b1}};
    dispat_info = '0; dispat_rs1 = '0; dispat_rs2 = '0; dispat_rs1_en = 1'b0;
    dispat_rs2_en = 1'b0; wb_rd = '0;
    repeat (2) @(posedge CLK);
    #1;
    total_cnt++; if (exe_vaild !== 1'b0) $display("FAIL reset_exe_vaild got %0b exp 0", exe_vaild); else pass_cnt++;
    total_cnt++; if (exe_info !== {DW{1'b0}}) $display("FAIL reset_exe_info got %0h exp 0", exe_info); else pass_cnt++;
    total_cnt++; if (exe_rs1 !== 7'd0 || exe_rs2 !== 7'd0) $display("FAIL reset_exe_rs got %0h/%0h exp 0/0", exe_rs1, exe_rs2); else pass_cnt++;
    total_cnt++; if (occupancy !== 3'd0) $display("FAIL reset_occupancy got %0d exp 0", occupancy); else pass_cnt++;
    total_cnt++; if (dispat_ready !== 1'b1) $display("FAIL reset_dispat_ready got %0b exp 1", dispat_ready); else pass_cnt++;
    RSTn = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_latency();
    logic [DW-1:0] a = DW'(32'hA0A0_0001);
    bit e1;
    bit e2;
`ifdef ISSUE_BYPASS_EN
    e1 = 1'b1; e2 = 1'b0;
`else
    e1 = 1'b0; e2 = 1'b1;
`endif
    reg_ready = {NR{1'b1}}; exe_ready = 1'b1;
    drive(a, 7'd5, 7'd6, 1'b1, 1'b1);
    tick(); idle();
    total_cnt++; if (exe_vaild !== e1) $display("FAIL lat_t1_valid got %0b exp %0b", exe_vaild, e1); else pass_cnt++;
    tick();
    total_cnt++; if (exe_vaild !== e2) $display("FAIL lat_t2_valid got %0b exp %0b", exe_vaild, e2); else pass_cnt++;
    if (e2) begin
      total_cnt++; if (exe_info !== a) $display("FAIL lat_info got %0h exp %0h", exe_info, a); else pass_cnt++;
      total_cnt++; if (exe_rs1 !== 7'd5 || exe_rs2 !== 7'd6) $display("FAIL lat_rs got %0d/%0d exp 5/6", exe_rs1, exe_rs2); else pass_cnt++;
    end
    tick();
    total_cnt++; if (exe_vaild !== 1'b0) $display("FAIL lat_drain got %0b exp 0", exe_vaild); else pass_cnt++;
  endtask

  task automatic test_fill_wakeup();
    reg_ready = {NR{1'b1}}; reg_ready[9] = 1'b0; exe_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(DW'(32'h100 + k), 7'd9, 7'd1, 1'b1, 1'b0);
      tick();
    end
    idle();
    total_cnt++; if (occupancy !== 3'd4) $display("FAIL fill_occ got %0d exp 4", occupancy); else pass_cnt++;
    total_cnt++; if (dispat_ready !== 1'b0) $display("FAIL fill_dispat_ready got %0b exp 0", dispat_ready); else pass_cnt++;
    total_cnt++; if (exe_vaild !== 1'b0) $display("FAIL fill_exe_vaild got %0b exp 0", exe_vaild); else pass_cnt++;
    // A ready op offered while full must be refused although one entry leaves.
    drive(DW'(32'hEEE), 7'd2, 7'd2, 1'b1, 1'b1);
    wb_vaild = 1'b1; wb_rd = 7'd9;
    tick(); idle();
    reg_ready[9] = 1'b1;
    total_cnt++; if (exe_vaild !== 1'b1 || exe_info !== DW'(32'h100)) $display("FAIL wake_first got %0b/%0h exp 1/100", exe_vaild, exe_info); else pass_cnt++;
    total_cnt++; if (occupancy !== 3'd3) $display("FAIL wake_full_refuse got %0d exp 3", occupancy); else pass_cnt++;
    for (int k = 1; k < 4; k++) begin
      tick();
      total_cnt++; if (exe_vaild !== 1'b1 || exe_info !== DW'(32'h100 + k)) $display("FAIL wake_order_%0d got %0b/%0h exp 1/%0h", k, exe_vaild, exe_info, 32'h100 + k); else pass_cnt++;
    end
    tick();
    total_cnt++; if (exe_vaild !== 1'b0 || occupancy !== 3'd0) $display("FAIL wake_empty got %0b/%0d exp 0/0", exe_vaild, occupancy); else pass_cnt++;
  endtask

  task automatic test_out_of_order();
    logic [DW-1:0] x = DW'(32'hCAFE_0001);
    logic [DW-1:0] y = DW'(32'hCAFE_0002);
    logic [DW-1:0] issued[$];
    reg_ready = {NR{1'b1}}; reg_ready[12] = 1'b0; exe_ready = 1'b1;
    drive(x, 7'd12, 7'd0, 1'b1, 1'b0); tick(); if (exe_vaild) issued.push_back(exe_info);
    drive(y, 7'd3, 7'd4, 1'b1, 1'b1);  tick(); if (exe_vaild) issued.push_back(exe_info);
    idle();
    repeat (2) begin tick(); if (exe_vaild) issued.push_back(exe_info); end
    total_cnt++; if (issued.size() != 1) $display("FAIL ooo_count got %0d exp 1", issued.size()); else pass_cnt++;
    if (issued.size() > 0) begin
      total_cnt++; if (issued[0] !== y) $display("FAIL ooo_first got %0h exp %0h", issued[0], y); else pass_cnt++;
    end
    total_cnt++; if (occupancy !== 3'd1) $display("FAIL ooo_occ got %0d exp 1", occupancy); else pass_cnt++;
    reg_ready[12] = 1'b1;
    tick();
    total_cnt++; if (exe_vaild !== 1'b1 || exe_info !== x) $display("FAIL ooo_late got %0b/%0h exp 1/%0h", exe_vaild, exe_info, x); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    reg_ready = {NR{1'b1}}; exe_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(DW'(32'hB00 + k), 7'd7, 7'd8, 1'b1, 1'b1);
      tick();
    end
    idle();
    for (int c = 0; c < 5; c++) begin
      total_cnt++; if (exe_vaild !== 1'b1 || exe_info !== DW'(32'hB00) || occupancy !== 3'd2)
        $display("FAIL bp_hold_%0d got %0b/%0h/%0d exp 1/b00/2", c, exe_vaild, exe_info, occupancy); else pass_cnt++;
      tick();
    end
    exe_ready = 1'b1;
    tick();
    total_cnt++; if (exe_vaild !== 1'b1 || exe_info !== DW'(32'hB01)) $display("FAIL bp_next got %0b/%0h exp 1/b01", exe_vaild, exe_info); else pass_cnt++;
    tick();
    total_cnt++; if (exe_vaild !== 1'b1 || exe_info !== DW'(32'hB02)) $display("FAIL bp_last got %0b/%0h exp 1/b02", exe_vaild, exe_info); else pass_cnt++;
    tick();
    total_cnt++; if (exe_vaild !== 1'b0 || occupancy !== 3'd0) $display("FAIL bp_empty got %0b/%0d exp 0/0", exe_vaild, occupancy); else pass_cnt++;
  endtask

  task automatic test_flush();
    reg_ready = {NR{1'b1}}; exe_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(DW'(32'hF00 + k), 7'd1, 7'd2, 1'b1, 1'b1);
      tick();
    end
    total_cnt++; if (occupancy !== 3'd3 || exe_vaild !== 1'b1) $display("FAIL flush_pre got %0d/%0b exp 3/1", occupancy, exe_vaild); else pass_cnt++;
    drive(DW'(32'hDEAD), 7'd1, 7'd2, 1'b1, 1'b1);
    flush = 1'b1; exe_ready = 1'b1;
    tick(); idle();
    total_cnt++; if (occupancy !== 3'd0) $display("FAIL flush_occ got %0d exp 0", occupancy); else pass_cnt++;
    total_cnt++; if (exe_vaild !== 1'b0) $display("FAIL flush_valid got %0b exp 0", exe_vaild); else pass_cnt++;
    total_cnt++; if (dispat_ready !== 1'b1) $display("FAIL flush_ready got %0b exp 1", dispat_ready); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      tick();
      total_cnt++; if (exe_vaild !== 1'b0) $display("FAIL flush_dropped_%0d got %0b exp 0", c, exe_vaild); else pass_cnt++;
    end
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] z = DW'(32'h2E20);
    bit e1;
    bit e2;
`ifdef ISSUE_BYPASS_EN
    e1 = 1'b1; e2 = 1'b0;
`else
    e1 = 1'b0; e2 = 1'b1;
`endif
    reg_ready = {NR{1'b1}}; reg_ready[0] = 1'b0; reg_ready[20] = 1'b0; exe_ready = 1'b1;
    drive(z, 7'd0, 7'd20, 1'b1, 1'b0);
    tick(); idle();
    total_cnt++; if (exe_vaild !== e1) $display("FAIL zero_t1 got %0b exp %0b", exe_vaild, e1); else pass_cnt++;
    tick();
    total_cnt++; if (exe_vaild !== e2) $display("FAIL zero_t2 got %0b exp %0b", exe_vaild, e2); else pass_cnt++;
    if (e2) begin
      total_cnt++; if (exe_info !== z) $display("FAIL zero_info got %0h exp %0h", exe_info, z); else pass_cnt++;
    end
    tick();
    reg_ready = {NR{1'b1}};
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      dispat_vaild  = ($urandom_range(0, 3) != 0);
      dispat_info   = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      dispat_rs1    = PW'($urandom_range(0, 15));
      dispat_rs2    = PW'($urandom_range(0, 15));
      dispat_rs1_en = 1'($urandom_range(0, 1));
      dispat_rs2_en = 1'($urandom_range(0, 1));
      if (c % 8 == 0) reg_ready[15:0] = 16'($urandom());
      wb_vaild      = ($urandom_range(0, 2) == 0);
      wb_rd         = PW'($urandom_range(0, 15));
      exe_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 49) == 0);
      tick();
      total_cnt++; if (exe_vaild !== m_slot_v) $display("FAIL rnd_valid c=%0d got %0b exp %0b", c, exe_vaild, m_slot_v); else pass_cnt++;
      if (m_slot_v) begin
        total_cnt++; if (exe_info !== m_slot.info) $display("FAIL rnd_info c=%0d got %0h exp %0h", c, exe_info, m_slot.info); else pass_cnt++;
        total_cnt++; if (exe_rs1 !== m_slot.rs1 || exe_rs2 !== m_slot.rs2) $display("FAIL rnd_rs c=%0d got %0d/%0d exp %0d/%0d", c, exe_rs1, exe_rs2, m_slot.rs1, m_slot.rs2); else pass_cnt++;
      end
      total_cnt++; if (occupancy !== 3'(m_q.size())) $display("FAIL rnd_occ c=%0d got %0d exp %0d", c, occupancy, m_q.size()); else pass_cnt++;
      total_cnt++; if (dispat_ready !== (m_q.size() < DP)) $display("FAIL rnd_ready c=%0d got %0b exp %0b", c, dispat_ready, (m_q.size() < DP)); else pass_cnt++;
    end
    idle(); reg_ready = {NR{1'b1}};
  endtask

  task automatic test_reset_mid();
    exe_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(DW'(32'h700 + k), 7'd1, 7'd1, 1'b1, 1'b1);
      tick();
    end
    idle();
    #2;
    RSTn = 1'b0;
    #1;
    total_cnt++; if (exe_vaild !== 1'b0 || exe_info !== {DW{1'b0}}) $display("FAIL rstmid_slot got %0b/%0h exp 0/0", exe_vaild, exe_info); else pass_cnt++;
    total_cnt++; if (occupancy !== 3'd0 || dispat_ready !== 1'b1) $display("FAIL rstmid_occ got %0d/%0b exp 0/1", occupancy, dispat_ready); else pass_cnt++;
    model_reset();
    @(negedge CLK);
    RSTn = 1'b1;
    exe_ready = 1'b1;
    tick();
    total_cnt++; if (exe_vaild !== 1'b0 || occupancy !== 3'd0) $display("FAIL rstmid_after got %0b/%0d exp 0/0", exe_vaild, occupancy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_wakeup();
    test_out_of_order();
    test_backpressure();
    test_flush();
    test_zero_reg();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
